// File: rtl/regfile.sv
// Two-read, one-write register file with x0 hardwired to zero and synchronous active-low reset.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              wr_en;
    logic [DATA_W-1:0] stored1;
    logic [DATA_W-1:0] stored2;

    // x0 is never written, so it stays at its reset value of zero.
    assign wr_en = we && (waddr != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign stored1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign stored2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // Forward only when the write will actually land at the coming edge.
    assign fwd1   = wr_en && rst_n && (raddr1 == waddr);
    assign fwd2   = wr_en && rst_n && (raddr2 == waddr);
    assign rdata1 = fwd1 ? wdata : stored1;
    assign rdata2 = fwd2 ? wdata : stored2;
`else
    assign rdata1 = stored1;
    assign rdata2 = stored2;
`endif

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations follow REGFILE_BYPASS_EN if defined.
module tb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    int n_checks;
    int n_fail;

    regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (rdata1),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a single write across one rising edge, then drop we.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic set_reads(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
        raddr1 = a1;
        raddr2 = a2;
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst_n = 1'b0;
        we    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            set_reads(ADDR_W'(i), ADDR_W'(31 - i));
            n_checks++;
            if (rdata1 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rd1[%0d]: got %h expected %h", i, rdata1, 32'h0);
            end
            n_checks++;
            if (rdata2 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rd2[%0d]: got %h expected %h", 31 - i, rdata2, 32'h0);
            end
        end
    endtask

    task automatic test_write_read;
        do_write(5'd5, 32'd123);
        set_reads(5'd5, 5'd4);
        n_checks++;
        if (rdata1 !== 32'd123) begin
            n_fail++;
            $display("FAIL wr_x5: got %0d expected %0d", rdata1, 123);
        end
        n_checks++;
        if (rdata2 !== 32'd0) begin
            n_fail++;
            $display("FAIL wr_x4_untouched: got %0d expected %0d", rdata2, 0);
        end
    endtask

    task automatic test_x0;
        do_write(5'd0, 32'd999);
        set_reads(5'd0, 5'd0);
        n_checks++;
        if (rdata1 !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_rd1: got %0d expected %0d", rdata1, 0);
        end
        n_checks++;
        if (rdata2 !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_rd2: got %0d expected %0d", rdata2, 0);
        end
    endtask

    task automatic test_patterns;
        do_write(5'd1, 32'hAAAA5555);
        do_write(5'd31, 32'hFFFFFFFF);
        set_reads(5'd1, 5'd31);
        n_checks++;
        if (rdata1 !== 32'hAAAA5555) begin
            n_fail++;
            $display("FAIL pat_x1: got %h expected %h", rdata1, 32'hAAAA5555);
        end
        n_checks++;
        if (rdata2 !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL pat_x31: got %h expected %h", rdata2, 32'hFFFFFFFF);
        end
        set_reads(5'd1, 5'd1);
        n_checks++;
        if (rdata1 !== 32'hAAAA5555 || rdata2 !== 32'hAAAA5555) begin
            n_fail++;
            $display("FAIL pat_same_addr: got %h/%h expected %h", rdata1, rdata2, 32'hAAAA5555);
        end
        do_write(5'd31, 32'h00000000);
        do_write(5'd1, 32'hFFFFFFFF);
        set_reads(5'd31, 5'd1);
        n_checks++;
        if (rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL pat_x31_zero: got %h expected %h", rdata1, 32'h0);
        end
        n_checks++;
        if (rdata2 !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL pat_x1_ones: got %h expected %h", rdata2, 32'hFFFFFFFF);
        end
    endtask

    task automatic test_we_low;
        @(negedge clk);
        we    = 1'b0;
        waddr = 5'd5;
        wdata = 32'd777;
        raddr1 = 5'd5;
        raddr2 = 5'd1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (rdata1 !== 32'd123) begin
            n_fail++;
            $display("FAIL we_low_x5: got %0d expected %0d", rdata1, 123);
        end
        n_checks++;
        if (rdata2 !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL we_low_x1: got %h expected %h", rdata2, 32'hFFFFFFFF);
        end
    endtask

    task automatic test_reset_priority;
        do_write(5'd7, 32'd42);
        @(negedge clk);
        rst_n  = 1'b0;
        we     = 1'b1;
        waddr  = 5'd7;
        wdata  = 32'd9;
        raddr1 = 5'd7;
        raddr2 = 5'd5;
        #1;
        n_checks++;
        if (rdata1 !== 32'd42) begin
            n_fail++;
            $display("FAIL rst_no_async_x7: got %0d expected %0d", rdata1, 42);
        end
        n_checks++;
        if (rdata2 !== 32'd123) begin
            n_fail++;
            $display("FAIL rst_no_async_x5: got %0d expected %0d", rdata2, 123);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rdata1 !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_prio_x7: got %0d expected %0d", rdata1, 0);
        end
        n_checks++;
        if (rdata2 !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_clr_x5: got %0d expected %0d", rdata2, 0);
        end
        we    = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_rdw;
        logic [DATA_W-1:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'd20;
`else
        exp_pre = 32'd10;
`endif
        do_write(5'd3, 32'd10);
        @(negedge clk);
        we     = 1'b1;
        waddr  = 5'd3;
        wdata  = 32'd20;
        raddr1 = 5'd3;
        raddr2 = 5'd3;
        #1;
        n_checks++;
        if (rdata1 !== exp_pre || rdata2 !== exp_pre) begin
            n_fail++;
            $display("FAIL rdw_pre: got %0d/%0d expected %0d", rdata1, rdata2, exp_pre);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata1 !== 32'd20 || rdata2 !== 32'd20) begin
            n_fail++;
            $display("FAIL rdw_post: got %0d/%0d expected %0d", rdata1, rdata2, 20);
        end
        @(negedge clk);
        we     = 1'b1;
        waddr  = 5'd0;
        wdata  = 32'd55;
        raddr1 = 5'd0;
        raddr2 = 5'd3;
        #1;
        n_checks++;
        if (rdata1 !== 32'd0) begin
            n_fail++;
            $display("FAIL rdw_x0_pre: got %0d expected %0d", rdata1, 0);
        end
        n_checks++;
        if (rdata2 !== 32'd20) begin
            n_fail++;
            $display("FAIL rdw_other_addr: got %0d expected %0d", rdata2, 20);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
        n_checks++;
        if (rdata1 !== 32'd0) begin
            n_fail++;
            $display("FAIL rdw_x0_post: got %0d expected %0d", rdata1, 0);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        we    = 1'b1;
        waddr = 5'd10;
        wdata = 32'd1;
        @(negedge clk);
        waddr = 5'd11;
        wdata = 32'd2;
        @(negedge clk);
        set_reads(5'd10, 5'd11);
        n_checks++;
        if (rdata1 !== 32'd1) begin
            n_fail++;
            $display("FAIL b2b_x10: got %0d expected %0d", rdata1, 1);
        end
        n_checks++;
        if (rdata2 !== 32'd2) begin
            n_fail++;
            $display("FAIL b2b_x11: got %0d expected %0d", rdata2, 2);
        end
        rst_n = 1'b0;
        waddr = 5'd12;
        wdata = 32'd3;
        @(negedge clk);
        rst_n = 1'b1;
        waddr = 5'd13;
        wdata = 32'd4;
        @(negedge clk);
        we = 1'b0;
        set_reads(5'd10, 5'd11);
        n_checks++;
        if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_cleared: got %0d/%0d expected 0/0", rdata1, rdata2);
        end
        set_reads(5'd12, 5'd13);
        n_checks++;
        if (rdata1 !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_x12_lost: got %0d expected %0d", rdata1, 0);
        end
        n_checks++;
        if (rdata2 !== 32'd4) begin
            n_fail++;
            $display("FAIL b2b_x13_after: got %0d expected %0d", rdata2, 4);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        we       = 1'b0;
        waddr    = '0;
        wdata    = '0;
        raddr1   = '0;
        raddr2   = '0;
        test_reset();
        test_write_read();
        test_x0();
        test_patterns();
        test_we_low();
        test_reset_priority();
        test_rdw();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The module SHALL provide parameter DATA_W, default 32, giving the register data width in bits.
REQ-002 The module SHALL provide parameter ADDR_W, default 5, giving the address width; depth = 2**ADDR_W (32 registers).
REQ-003 The module SHALL have one clock and a synchronous, active-low reset, with ports as follows:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- we  input  1  write enable.
- waddr  input  ADDR_W  write register index.
- wdata  input  DATA_W  write data.
- raddr1  input  ADDR_W  read port 1 register index.
- raddr2  input  ADDR_W  read port 2 register index.
- rdata1  output  DATA_W  read port 1 data.
- rdata2  output  DATA_W  read port 2 data.

Function
REQ-004 The module SHALL hold 2**ADDR_W registers, x0..x(N-1), each DATA_W bits wide.
REQ-005 On a rising clk edge with rst_n=1, we=1 and waddr!=0, the module SHALL store wdata into register waddr.
REQ-006 A write with waddr=0 SHALL be discarded; x0 SHALL always read as 0.
REQ-007 With we=0, no register SHALL change.
REQ-008 Reads SHALL be combinational (zero latency): rdataN SHALL equal register raddrN in the same cycle.
REQ-009 A value written at edge k SHALL be visible on any read port addressing it immediately after edge k.
REQ-010 Both read ports SHALL be independent; raddr1 and raddr2 SHALL be allowed to address the same register or x0 at the same time.
REQ-011 Read-during-write to the same nonzero address in the same cycle SHALL follow REQ-020/REQ-021.
REQ-012 Writes of all-zero and all-ones data SHALL be stored exactly; no arithmetic, sign handling or truncation SHALL be applied.

Reset
REQ-013 On a rising clk edge with rst_n=0, all registers SHALL be cleared to 0.
REQ-014 Reset SHALL take priority over a simultaneous write; the write SHALL be lost.
REQ-015 Reset SHALL have no asynchronous effect; until the next rising edge, registers SHALL keep their prior values.
REQ-016 After reset, rdata1 and rdata2 SHALL read 0 for every address until a write occurs.
REQ-017 A reset asserted between back-to-back writes SHALL clear all earlier writes; writes after release SHALL behave normally.

Configuration
REQ-018 The macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-019 Forwarding SHALL be the only compile-time option; all other behaviour SHALL be identical in both builds.
REQ-020 When REGFILE_BYPASS_EN is defined, if we=1, rst_n=1, waddr!=0 and raddrN==waddr, rdataN SHALL combinationally equal wdata in the same cycle.
REQ-021 When REGFILE_BYPASS_EN is undefined, rdataN SHALL return the stored (old) value until the write edge; forwarding SHALL never apply to x0.

Verification
REQ-022 Write x5=123 (we=1, waddr=5, wdata=123) for one edge, then we=0, raddr1=5 -> rdata1=123.
REQ-023 Write waddr=0, wdata=999, then raddr1=0 -> rdata1=0; raddr2=0 -> rdata2=0.
REQ-024 Write x1=0xAAAA5555 and x31=0xFFFFFFFF, then raddr1=1 and raddr2=31 -> rdata1=0xAAAA5555, rdata2=0xFFFFFFFF.
REQ-025 Write x7=42, then rst_n=0 for one edge with we=1, waddr=7, wdata=9 -> rdata1 for raddr1=7 reads 0.
REQ-026 With x3=10 and we=1, waddr=3, wdata=20, read raddr1=3 before the edge -> 20 with REGFILE_BYPASS_EN, 10 without; after the edge -> 20 in both builds.
